// File: rtl/accel_loader_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : accel_loader_pkg
// Brief    : Command encodings, FSM states and status-word layout shared by
//            the host loader and its status formatter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package accel_loader_pkg;

  localparam logic [3:0] CMD_LOAD_I = 4'd1;
  localparam logic [3:0] CMD_LOAD_D = 4'd2;
  localparam logic [3:0] CMD_RUN    = 4'd3;
  localparam logic [3:0] CMD_READ_D = 4'd4;

  localparam int c_STAT_CMD_LSB     = 28;
  localparam int c_STAT_ERR_BIT     = 27;
  localparam int c_STAT_WRAP_BIT    = 26;
  localparam int c_STAT_TIMEOUT_BIT = 25;
  localparam int c_STAT_LEN_LSB     = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_I   = 3'd1,
    ST_LOAD_D   = 3'd2,
    ST_RUN_WAIT = 3'd3,
    ST_RD_REQ   = 3'd4,
    ST_RD_CAP   = 3'd5,
    ST_RD_SEND  = 3'd6,
    ST_STATUS   = 3'd7
  } state_t;

  function automatic logic cmd_is_known(input logic [3:0] cmd);
    return (cmd == CMD_LOAD_I) || (cmd == CMD_LOAD_D) ||
           (cmd == CMD_RUN)    || (cmd == CMD_READ_D);
  endfunction

  function automatic logic state_accepts(input state_t s);
    return (s == ST_IDLE) || (s == ST_LOAD_I) || (s == ST_LOAD_D);
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_loader_status.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : accel_loader_status
// Brief    : Combinational status-word formatter, including the wrap check.
//            ACCEL_LOADER_CYCLE_COUNT_EN exposes the RUN cycle count in [15:0].
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module accel_loader_status #(
  parameter int INSTR_DEPTH = 16,
  parameter int DATA_DEPTH  = 32
) (
  input  logic [3:0]  i_cmd,
  input  logic [4:0]  i_base,
  input  logic [4:0]  i_len,
  input  logic        i_timeout,
  input  logic [15:0] i_cycles,
  output logic [31:0] o_word
);
  import accel_loader_pkg::*;

  logic [5:0]  w_sum;
  logic        w_wrap;
  logic        w_err;
  logic [15:0] w_count;

  assign w_sum = {1'b0, i_base} + {1'b0, i_len};
  assign w_err = !cmd_is_known(i_cmd);

  // A base beyond the depth is flagged even when len is 0.
  always_comb begin
    w_wrap = 1'b0;
    case (i_cmd)
      CMD_LOAD_I: w_wrap = (32'(w_sum) > 32'(INSTR_DEPTH)) || (32'(i_base) >= 32'(INSTR_DEPTH));
      CMD_LOAD_D,
      CMD_READ_D: w_wrap = (32'(w_sum) > 32'(DATA_DEPTH)) || (32'(i_base) >= 32'(DATA_DEPTH));
      default:    w_wrap = 1'b0;
    endcase
  end

`ifdef ACCEL_LOADER_CYCLE_COUNT_EN
  assign w_count = (i_cmd == CMD_RUN) ? i_cycles : 16'h0;
`else
  logic w_unused_cycles;
  assign w_unused_cycles = ^i_cycles;
  assign w_count         = 16'h0;
`endif

  always_comb begin
    o_word                           = 32'h0;
    o_word[c_STAT_CMD_LSB +: 4]      = i_cmd;
    o_word[c_STAT_ERR_BIT]           = w_err;
    o_word[c_STAT_WRAP_BIT]          = w_wrap;
    o_word[c_STAT_TIMEOUT_BIT]       = i_timeout;
    o_word[c_STAT_LEN_LSB +: 5]      = i_len;
    o_word[15:0]                     = w_count;
  end

endmodule
`default_nettype wire

// File: rtl/accel_host_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : accel_host_loader
// Brief    : Host command/response bridge that loads accelerator memories,
//            launches a run, reads data back and reports one status word per
//            command. Optional macro: ACCEL_LOADER_CYCLE_COUNT_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module accel_host_loader #(
  parameter int INSTR_DEPTH = 16,
  parameter int DATA_DEPTH  = 32,
  parameter int RUN_TIMEOUT = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_data,
  output logic                           instr_we,
  output logic [$clog2(INSTR_DEPTH)-1:0] instr_addr,
  output logic [31:0]                    instr_wdata,
  output logic                           data_we,
  output logic                           data_re,
  output logic [$clog2(DATA_DEPTH)-1:0]  data_addr,
  output logic [15:0]                    data_wdata,
  input  logic [15:0]                    data_rdata,
  output logic                           accel_start,
  input  logic                           accel_halted
);
  import accel_loader_pkg::*;

  localparam int c_IAW = $clog2(INSTR_DEPTH);
  localparam int c_DAW = $clog2(DATA_DEPTH);

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic [3:0]         r_cmd;
  logic [4:0]         r_base;
  logic [4:0]         r_len;
  logic [4:0]         r_idx;
  logic               r_timeout;
  logic [15:0]        r_cycles;
  logic [15:0]        r_rdata;
  logic               r_instr_we;
  logic [c_IAW-1:0]   r_instr_addr;
  logic [31:0]        r_instr_wdata;
  logic               r_data_we;
  logic               r_data_re;
  logic [c_DAW-1:0]   r_data_addr;
  logic [15:0]        r_data_wdata;
  logic               r_accel_start;

  logic               w_in_fire;
  logic [3:0]         w_hdr_cmd;
  logic [4:0]         w_hdr_base;
  logic [4:0]         w_hdr_len;
  logic [4:0]         w_idx_inc;
  logic               w_last;
  logic [4:0]         w_wr_addr;
  logic [4:0]         w_rd_addr;
  logic [15:0]        w_cyc_inc;
  logic               w_to_hit;
  logic               w_halt_seen;
  logic [31:0]        w_status;

  assign w_in_fire   = in_valid & r_in_ready;
  assign w_hdr_cmd   = in_data[31:28];
  assign w_hdr_base  = in_data[20:16];
  assign w_hdr_len   = in_data[4:0];
  assign w_idx_inc   = r_idx + 5'd1;
  assign w_last      = (w_idx_inc == r_len);
  assign w_wr_addr   = r_base + r_idx;
  assign w_rd_addr   = r_base + w_idx_inc;
  assign w_cyc_inc   = (r_cycles == 16'hFFFF) ? r_cycles : r_cycles + 16'd1;
  assign w_to_hit    = (32'(w_cyc_inc) == 32'(RUN_TIMEOUT));
  // The start pulse cycle is blind to a stale halted flag from a previous run.
  assign w_halt_seen = accel_halted & ~r_accel_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          case (w_hdr_cmd)
            CMD_LOAD_I: w_next = (w_hdr_len == 5'd0) ? ST_STATUS : ST_LOAD_I;
            CMD_LOAD_D: w_next = (w_hdr_len == 5'd0) ? ST_STATUS : ST_LOAD_D;
            CMD_RUN:    w_next = ST_RUN_WAIT;
            CMD_READ_D: w_next = (w_hdr_len == 5'd0) ? ST_STATUS : ST_RD_REQ;
            default:    w_next = ST_STATUS;
          endcase
        end
      end
      ST_LOAD_I,
      ST_LOAD_D:   if (w_in_fire && w_last) w_next = ST_STATUS;
      ST_RUN_WAIT: if (w_halt_seen || w_to_hit) w_next = ST_STATUS;
      ST_RD_REQ:   w_next = ST_RD_CAP;
      ST_RD_CAP:   w_next = ST_RD_SEND;
      ST_RD_SEND:  if (out_ready) w_next = w_last ? ST_STATUS : ST_RD_REQ;
      ST_STATUS:   if (out_ready) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready    <= 1'b0;
      r_cmd         <= '0;
      r_base        <= '0;
      r_len         <= '0;
      r_idx         <= '0;
      r_timeout     <= 1'b0;
      r_cycles      <= '0;
      r_rdata       <= '0;
      r_instr_we    <= 1'b0;
      r_instr_addr  <= '0;
      r_instr_wdata <= '0;
      r_data_we     <= 1'b0;
      r_data_re     <= 1'b0;
      r_data_addr   <= '0;
      r_data_wdata  <= '0;
      r_accel_start <= 1'b0;
    end else begin
      r_in_ready    <= state_accepts(w_next);
      r_instr_we    <= 1'b0;
      r_data_we     <= 1'b0;
      r_data_re     <= 1'b0;
      r_accel_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_in_fire) begin
            r_cmd         <= w_hdr_cmd;
            r_base        <= w_hdr_base;
            r_len         <= w_hdr_len;
            r_idx         <= '0;
            r_timeout     <= 1'b0;
            r_cycles      <= '0;
            r_accel_start <= (w_next == ST_RUN_WAIT);
            if (w_next == ST_RD_REQ) begin
              r_data_re   <= 1'b1;
              r_data_addr <= w_hdr_base[c_DAW-1:0];
            end
          end
        end
        ST_LOAD_I: begin
          if (w_in_fire) begin
            r_instr_we    <= 1'b1;
            r_instr_addr  <= w_wr_addr[c_IAW-1:0];
            r_instr_wdata <= in_data;
            r_idx         <= w_idx_inc;
          end
        end
        ST_LOAD_D: begin
          if (w_in_fire) begin
            r_data_we    <= 1'b1;
            r_data_addr  <= w_wr_addr[c_DAW-1:0];
            r_data_wdata <= in_data[15:0];
            r_idx        <= w_idx_inc;
          end
        end
        ST_RUN_WAIT: begin
          if (!w_halt_seen) begin
            r_cycles <= w_cyc_inc;
            if (w_to_hit) r_timeout <= 1'b1;
          end
        end
        ST_RD_CAP: r_rdata <= data_rdata;
        ST_RD_SEND: begin
          if (out_ready) begin
            r_idx <= w_idx_inc;
            if (!w_last) begin
              r_data_re   <= 1'b1;
              r_data_addr <= w_rd_addr[c_DAW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  accel_loader_status #(
    .INSTR_DEPTH (INSTR_DEPTH),
    .DATA_DEPTH  (DATA_DEPTH)
  ) u_status (
    .i_cmd     (r_cmd),
    .i_base    (r_base),
    .i_len     (r_len),
    .i_timeout (r_timeout),
    .i_cycles  (r_cycles),
    .o_word    (w_status)
  );

  always_comb begin
    out_data = 32'h0;
    case (r_state)
      ST_RD_SEND: out_data = {16'h0, r_rdata};
      ST_STATUS:  out_data = w_status;
      default:    out_data = 32'h0;
    endcase
  end

  assign out_valid   = (r_state == ST_RD_SEND) || (r_state == ST_STATUS);
  assign in_ready    = r_in_ready;
  assign instr_we    = r_instr_we;
  assign instr_addr  = r_instr_addr;
  assign instr_wdata = r_instr_wdata;
  assign data_we     = r_data_we;
  assign data_re     = r_data_re;
  assign data_addr   = r_data_addr;
  assign data_wdata  = r_data_wdata;
  assign accel_start = r_accel_start;

endmodule
`default_nettype wire
